// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcodes, control-bit
// positions, named control words, T-state encoding and execute-phase decode.
package sap1_pkg;

  localparam int unsigned SAP_OPCODE_W = 4;
  localparam int unsigned SAP_CON_W    = 12;
  localparam int unsigned SAP_RING_LEN = 6;

  typedef logic [SAP_OPCODE_W-1:0] opcode_t;
  typedef logic [SAP_CON_W-1:0]    con_t;

  localparam opcode_t OP_LDA = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_OUT = 4'b1110;
  localparam opcode_t OP_HLT = 4'b1111;

  localparam int unsigned CON_CP     = 11;
  localparam int unsigned CON_EP     = 10;
  localparam int unsigned CON_LM_BAR = 9;
  localparam int unsigned CON_CE_BAR = 8;
  localparam int unsigned CON_LI_BAR = 7;
  localparam int unsigned CON_EI_BAR = 6;
  localparam int unsigned CON_LA_BAR = 5;
  localparam int unsigned CON_EA     = 4;
  localparam int unsigned CON_SU     = 3;
  localparam int unsigned CON_EU     = 2;
  localparam int unsigned CON_LB_BAR = 1;
  localparam int unsigned CON_LO_BAR = 0;

  function automatic con_t con_bit(input int unsigned idx);
    return con_t'(1) << idx;
  endfunction

  // Every word is the idle word with the asserted lines flipped.
  localparam con_t CON_NOP    = con_bit(CON_LM_BAR) | con_bit(CON_CE_BAR) | con_bit(CON_LI_BAR)
                              | con_bit(CON_EI_BAR) | con_bit(CON_LA_BAR) | con_bit(CON_LB_BAR)
                              | con_bit(CON_LO_BAR);
  localparam con_t CON_T1     = CON_NOP ^ con_bit(CON_EP) ^ con_bit(CON_LM_BAR);
  localparam con_t CON_T2     = CON_NOP ^ con_bit(CON_CP);
  localparam con_t CON_T3     = CON_NOP ^ con_bit(CON_CE_BAR) ^ con_bit(CON_LI_BAR);
  localparam con_t CON_MAR_T4 = CON_NOP ^ con_bit(CON_LM_BAR) ^ con_bit(CON_EI_BAR);
  localparam con_t CON_LDA_T5 = CON_NOP ^ con_bit(CON_CE_BAR) ^ con_bit(CON_LA_BAR);
  localparam con_t CON_ALU_T5 = CON_NOP ^ con_bit(CON_CE_BAR) ^ con_bit(CON_LB_BAR);
  localparam con_t CON_ADD_T6 = CON_NOP ^ con_bit(CON_LA_BAR) ^ con_bit(CON_EU);
  localparam con_t CON_SUB_T6 = CON_NOP ^ con_bit(CON_LA_BAR) ^ con_bit(CON_SU) ^ con_bit(CON_EU);
  localparam con_t CON_OUT_T4 = CON_NOP ^ con_bit(CON_EA) ^ con_bit(CON_LO_BAR);

  typedef enum logic [SAP_RING_LEN-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  // Execute-phase word; phase 0/1/2 corresponds to T4/T5/T6.
  function automatic con_t exec_word(input opcode_t op, input logic [1:0] phase);
    con_t w;
    w = CON_NOP;
    unique case (op)
      OP_LDA: w = (phase == 2'd0) ? CON_MAR_T4 : (phase == 2'd1) ? CON_LDA_T5 : CON_NOP;
      OP_ADD: w = (phase == 2'd0) ? CON_MAR_T4 : (phase == 2'd1) ? CON_ALU_T5 : CON_ADD_T6;
      OP_SUB: w = (phase == 2'd0) ? CON_MAR_T4 : (phase == 2'd1) ? CON_ALU_T5 : CON_SUB_T6;
      OP_OUT: w = (phase == 2'd0) ? CON_OUT_T4 : CON_NOP;
      default: w = CON_NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Falling-edge one-hot T-state ring counter with asynchronous clear to T1
// and a hold input that freezes the current state.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic     CLK,
  input  logic     CLR,
  input  logic     hold,
  output t_state_e state
);

  t_state_e state_next;

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= T1;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!hold) begin
      unique case (state)
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = T4;
        T4:      state_next = T5;
        T5:      state_next = T6;
        T6:      state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: decodes the T-state and IR opcode into the
// datapath control word, and latches a sticky halt on HLT at T4.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int unsigned OPCODE_W = SAP_OPCODE_W,
  parameter int unsigned CON_W    = SAP_CON_W,
  parameter int unsigned RING_LEN = SAP_RING_LEN
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CON_W-1:0]    con,
  output logic [RING_LEN-1:0] t_state,
  output logic                hlt
);

  generate
    if (RING_LEN != 6 || OPCODE_W != SAP_OPCODE_W || CON_W != SAP_CON_W) begin : g_bad_param
      $error("sap1_controller: only RING_LEN=6, OPCODE_W=4, CON_W=12 are supported");
    end
  endgenerate

  opcode_t  op;
  t_state_e state;
  logic     halt_req;
  logic     hold;
  logic     hlt_next;
  con_t     con_word;

  assign op       = SAP_OPCODE_W'(opcode);
  assign halt_req = (state == T4) && (op == OP_HLT);
  assign hold     = hlt | halt_req;

  sap1_ring_counter u_ring (
    .CLK   (CLK),
    .CLR   (CLR),
    .hold  (hold),
    .state (state)
  );

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      hlt <= 1'b0;
    end else begin
      hlt <= hlt_next;
    end
  end

  always_comb begin
    hlt_next = hlt | halt_req;
  end

  // CLR and halt override decode so no datapath register loads.
  always_comb begin
    con_word = CON_NOP;
    if (!CLR && !hlt) begin
      unique case (state)
        T1:      con_word = CON_T1;
        T2:      con_word = CON_T2;
        T3:      con_word = CON_T3;
        T4:      con_word = exec_word(op, 2'd0);
        T5:      con_word = exec_word(op, 2'd1);
        T6:      con_word = exec_word(op, 2'd2);
        default: con_word = CON_NOP;
      endcase
    end
  end

  assign con     = CON_W'(con_word);
  assign t_state = RING_LEN'(state);

endmodule
